// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the fetch PC, arbitrates redirects (trap > jalr > br > jal), holds them until fetch is ready, then flushes.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_if_ready,
  input  logic        io_stall,
  input  logic        io_br_taken,
  input  logic [31:0] io_br_target,
  input  logic        io_jal,
  input  logic [31:0] io_jal_target,
  input  logic        io_jalr,
  input  logic [31:0] io_jalr_target,
  input  logic        io_trap,
  input  logic [31:0] io_trap_vec,
  output logic [31:0] io_pc,
  output logic        io_pc_valid,
  output logic        io_jmp_br_jalr_mux_sel,
  output logic [1:0]  io_pc_mux_sel,
  output logic        io_flush,
  output logic        io_redirect_pending,
  output logic        io_misalign
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_e;
  localparam logic [2:0] SRC_NONE = 3'd0, SRC_JAL = 3'd1, SRC_BR = 3'd2, SRC_JALR = 3'd3, SRC_TRAP = 3'd4;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, req_tgt, app_tgt;
  logic [2:0]  pend_src_q, pend_src_d, req_src, app_src, cnt_q, cnt_d;
  logic [1:0]  psel_q, psel_d;
  logic        valid_q, valid_d, jsel_q, jsel_d, mis_q, mis_d, take, adv;
  always_comb begin
    req_src = io_trap ? SRC_TRAP : io_jalr ? SRC_JALR : io_br_taken ? SRC_BR : io_jal ? SRC_JAL : SRC_NONE;
    req_tgt = io_trap ? io_trap_vec : io_jalr ? {io_jalr_target[31:1], 1'b0} : io_br_taken ? io_br_target : io_jal_target;
    app_src = (state_q == HOLD && req_src <= pend_src_q) ? pend_src_q : req_src;
    app_tgt = (state_q == HOLD && req_src <= pend_src_q) ? pend_tgt_q : req_tgt;
    take    = state_q == RUN ? req_src != SRC_NONE : state_q == FLUSH ? io_trap : state_q == HOLD;
    adv     = io_if_ready && !io_stall;
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    jsel_d     = 1'b0;
    psel_d     = psel_q;
    mis_d      = 1'b0;
    cnt_d      = cnt_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    if (state_q == BOOT) begin
      state_d = RUN;
      valid_d = 1'b1;
      psel_d  = 2'd0;
    end else if (take && io_if_ready) begin
      pc_d       = app_tgt;
      psel_d     = app_src == SRC_TRAP ? 2'd2 : 2'd1;
      jsel_d     = app_src == SRC_JALR;
      mis_d      = (app_src == SRC_BR || app_src == SRC_JAL) && app_tgt[1:0] != 2'b00;
      cnt_d      = 3'(FLUSH_CYCLES);
      state_d    = FLUSH;
      pend_src_d = SRC_NONE;
    end else if (take) begin
      state_d    = HOLD;
      pend_src_d = app_src;
      pend_tgt_d = app_tgt;
      psel_d     = 2'd3;
    end else begin
      pc_d   = adv ? pc_q + 32'd4 : pc_q;
      psel_d = adv ? 2'd0 : 2'd3;
      cnt_d  = state_q == FLUSH ? cnt_q - 3'd1 : cnt_q;
      state_d = (state_q == FLUSH && cnt_d == 3'd0) ? RUN : state_q;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      jsel_q     <= 1'b0;
      psel_q     <= 2'd0;
      mis_q      <= 1'b0;
      cnt_q      <= 3'd0;
      pend_src_q <= SRC_NONE;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      jsel_q     <= jsel_d;
      psel_q     <= psel_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
  assign io_pc                  = pc_q;
  assign io_pc_valid            = valid_q;
  assign io_jmp_br_jalr_mux_sel = jsel_q;
  assign io_pc_mux_sel          = psel_q;
  assign io_flush               = state_q == FLUSH && cnt_q != 3'd0;
  assign io_redirect_pending    = state_q == HOLD;
  assign io_misalign            = mis_q;
endmodule
